// File: rtl/axi_ctrl_arb_pkg.sv
// axi_ctrl_arb_pkg
//   Shared types for the AXI control arbiter: backend FSM states and
//   the round-robin grant owner.
package axi_ctrl_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LM_WR = 2'd1,
      LM_RD = 2'd2,
      SM_TX = 2'd3
   } state_t;

   typedef enum logic {
      GNT_LS = 1'b0,
      GNT_SS = 1'b1
   } grant_t;

endpackage

// File: rtl/axi_ctrl_arb_if.sv
// axi_ctrl_arb_if
//   Backend handshake bundle of the arbiter.
//   slave  : view of axi_ctrl_arb (takes LS/SS requests, drives LM/SM).
//   master : view of the surrounding environment.
//   bk_ls_* : AXI-Lite slave request side + read return
//   bk_lm_* : AXI-Lite master backend (start pulses, done inputs)
//   bk_ss_* : AXI-Stream slave beats in, ready out
//   bk_sm_* : AXI-Stream master backend (start pulse, nordy/done inputs)
interface axi_ctrl_arb_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int USER_W = 2
);
   import axi_ctrl_arb_pkg::*;
   localparam int STRB_W = DATA_W / 8;

   logic              bk_ls_wstart, bk_ls_rstart;
   logic [ADDR_W-1:0] bk_ls_waddr, bk_ls_raddr;
   logic [DATA_W-1:0] bk_ls_wdata;
   logic [STRB_W-1:0] bk_ls_wstrb;
   logic [DATA_W-1:0] bk_ls_rdata;
   logic              bk_ls_rdone;

   logic              bk_lm_wstart, bk_lm_rstart;
   logic [31:0]       bk_lm_waddr, bk_lm_raddr;
   logic [DATA_W-1:0] bk_lm_wdata;
   logic [STRB_W-1:0] bk_lm_wstrb;
   logic              bk_lm_wdone, bk_lm_rdone;
   logic [DATA_W-1:0] bk_lm_rdata;

   logic [DATA_W-1:0] bk_ss_data;
   logic [STRB_W-1:0] bk_ss_tstrb, bk_ss_tkeep;
   logic [USER_W-1:0] bk_ss_user;
   logic              bk_ss_tlast, bk_ss_valid, bk_ss_ready;

   logic              bk_sm_start;
   logic [DATA_W-1:0] bk_sm_data;
   logic [STRB_W-1:0] bk_sm_tstrb, bk_sm_tkeep;
   logic [USER_W-1:0] bk_sm_user;
   logic              bk_sm_tlast, bk_sm_nordy, bk_sm_done;

   modport slave (
      input  bk_ls_wstart, bk_ls_rstart, bk_ls_waddr, bk_ls_raddr,
             bk_ls_wdata, bk_ls_wstrb,
      output bk_ls_rdata, bk_ls_rdone,
      output bk_lm_wstart, bk_lm_rstart, bk_lm_waddr, bk_lm_raddr,
             bk_lm_wdata, bk_lm_wstrb,
      input  bk_lm_wdone, bk_lm_rdone, bk_lm_rdata,
      input  bk_ss_data, bk_ss_tstrb, bk_ss_tkeep, bk_ss_user,
             bk_ss_tlast, bk_ss_valid,
      output bk_ss_ready,
      output bk_sm_start, bk_sm_data, bk_sm_tstrb, bk_sm_tkeep,
             bk_sm_user, bk_sm_tlast,
      input  bk_sm_nordy, bk_sm_done
   );

   modport master (
      output bk_ls_wstart, bk_ls_rstart, bk_ls_waddr, bk_ls_raddr,
             bk_ls_wdata, bk_ls_wstrb,
      input  bk_ls_rdata, bk_ls_rdone,
      input  bk_lm_wstart, bk_lm_rstart, bk_lm_waddr, bk_lm_raddr,
             bk_lm_wdata, bk_lm_wstrb,
      output bk_lm_wdone, bk_lm_rdone, bk_lm_rdata,
      output bk_ss_data, bk_ss_tstrb, bk_ss_tkeep, bk_ss_user,
             bk_ss_tlast, bk_ss_valid,
      input  bk_ss_ready,
      input  bk_sm_start, bk_sm_data, bk_sm_tstrb, bk_sm_tkeep,
             bk_sm_user, bk_sm_tlast,
      output bk_sm_nordy, bk_sm_done
   );
endinterface

// File: rtl/axi_ctrl_arb_fifo.sv
// ctrl_sync_fifo
//   Single-clock FIFO, power-of-2 DEPTH, async active-high reset.
//   i_clk/i_rst     : clock, async reset
//   i_clear         : synchronous flush
//   i_wr_vld/o_wr_rdy/i_wr_data : write side; o_wr_rdy also high when
//                     full but popping this cycle (slot freed in place)
//   o_rd_vld/i_rd_rdy/o_rd_data : read side (first-word fall-through)
//   o_count         : occupancy
module ctrl_sync_fifo
   import axi_ctrl_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_clear,
   input  logic                           i_wr_vld,
   output logic                           o_wr_rdy,
   input  logic [WIDTH-1:0]               i_wr_data,
   output logic                           o_rd_vld,
   input  logic                           i_rd_rdy,
   output logic [WIDTH-1:0]               o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_full, w_push, w_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign o_rd_vld  = (r_count != '0);
   assign w_pop     = o_rd_vld && i_rd_rdy;
   assign o_wr_rdy  = !w_full || w_pop;
   assign w_push    = i_wr_vld && o_wr_rdy;
   assign o_rd_data = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wr_data;
   end

   // Pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/axi_ctrl_arb.sv
// axi_ctrl_arb
//   Buffers AXI-Lite slave requests and AXI-Stream slave beats in FIFOs,
//   round-robins them onto the LM / SM backend handshakes and returns LM
//   read data to LS. Optional packet-atomic stream forwarding; sticky
//   overflow interrupt for dropped LS requests.
//   axi_aclk/axi_areset : clock, async active-high reset
//   axi_interrupt       : sticky overflow flag
//   irq_clr             : clears overflow flag (a same-cycle drop wins)
//   ls_level/ss_level   : FIFO occupancy
//   bus                 : backend handshake bundle (slave view)
module axi_ctrl_arb
   import axi_ctrl_arb_pkg::*;
#(
   parameter int          ADDR_W      = 15,
   parameter int          DATA_W      = 32,
   parameter int          USER_W      = 2,
   parameter int          LS_DEPTH    = 8,
   parameter int          SS_DEPTH    = 8,
   parameter bit          SS_PKT_MODE = 1'b1,
   parameter logic [31:0] LM_BASE     = 32'h0
) (
   input  logic                            axi_aclk,
   input  logic                            axi_areset,
   output logic                            axi_interrupt,
   input  logic                            irq_clr,
   output logic [$clog2(LS_DEPTH+1)-1:0]   ls_level,
   output logic [$clog2(SS_DEPTH+1)-1:0]   ss_level,
   axi_ctrl_arb_if.slave                   bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LS_W   = 1 + ADDR_W + DATA_W + STRB_W;
   localparam int SS_W   = DATA_W + 2*STRB_W + USER_W + 1;

   // ---------------- LS request FIFO ----------------
   logic              w_ls_req, w_ls_both, w_ls_drop, w_ls_wr_rdy;
   logic              w_ls_vld, w_ls_pop;
   logic [LS_W-1:0]   w_ls_din, w_ls_dout;
   logic              w_ls_is_rd;
   logic [ADDR_W-1:0] w_ls_addr;
   logic [DATA_W-1:0] w_ls_data;
   logic [STRB_W-1:0] w_ls_strb;

   assign w_ls_req  = bus.bk_ls_wstart || bus.bk_ls_rstart;
   assign w_ls_both = bus.bk_ls_wstart && bus.bk_ls_rstart;
   // A write takes priority over a simultaneous read; reads carry no payload.
   assign w_ls_din  = bus.bk_ls_wstart ?
                      {1'b0, bus.bk_ls_waddr, bus.bk_ls_wdata, bus.bk_ls_wstrb} :
                      {1'b1, bus.bk_ls_raddr, {DATA_W{1'b0}}, {STRB_W{1'b0}}};
   assign w_ls_drop = (w_ls_req && !w_ls_wr_rdy) || w_ls_both;
   assign {w_ls_is_rd, w_ls_addr, w_ls_data, w_ls_strb} = w_ls_dout;

   ctrl_sync_fifo #(.WIDTH(LS_W), .DEPTH(LS_DEPTH)) u_ls_fifo (
      .i_clk(axi_aclk), .i_rst(axi_areset), .i_clear(1'b0),
      .i_wr_vld(w_ls_req), .o_wr_rdy(w_ls_wr_rdy), .i_wr_data(w_ls_din),
      .o_rd_vld(w_ls_vld), .i_rd_rdy(w_ls_pop), .o_rd_data(w_ls_dout),
      .o_count(ls_level)
   );

   // ---------------- SS beat FIFO ----------------
   logic              r_ss_en, w_ss_full, w_ss_wr_rdy, w_ss_push;
   logic              w_ss_vld, w_ss_pop;
   logic [SS_W-1:0]   w_ss_din, w_ss_dout;
   logic [DATA_W-1:0] w_ss_data;
   logic [STRB_W-1:0] w_ss_tstrb, w_ss_tkeep;
   logic [USER_W-1:0] w_ss_user;
   logic              w_ss_tlast;

   // Ready comes from registered occupancy only, so there is no path from
   // the SM backend to bk_ss_ready; r_ss_en keeps it low during reset.
   assign w_ss_full       = (ss_level == ($clog2(SS_DEPTH+1))'(SS_DEPTH));
   assign bus.bk_ss_ready = r_ss_en && !w_ss_full;
   assign w_ss_push       = bus.bk_ss_valid && bus.bk_ss_ready && w_ss_wr_rdy;
   assign w_ss_din        = {bus.bk_ss_data, bus.bk_ss_tstrb, bus.bk_ss_tkeep,
                             bus.bk_ss_user, bus.bk_ss_tlast};
   assign {w_ss_data, w_ss_tstrb, w_ss_tkeep, w_ss_user, w_ss_tlast} = w_ss_dout;

   ctrl_sync_fifo #(.WIDTH(SS_W), .DEPTH(SS_DEPTH)) u_ss_fifo (
      .i_clk(axi_aclk), .i_rst(axi_areset), .i_clear(1'b0),
      .i_wr_vld(w_ss_push), .o_wr_rdy(w_ss_wr_rdy), .i_wr_data(w_ss_din),
      .o_rd_vld(w_ss_vld), .i_rd_rdy(w_ss_pop), .o_rd_data(w_ss_dout),
      .o_count(ss_level)
   );

   // ---------------- arbitration FSM ----------------
   state_t            r_state;
   grant_t            r_last;
   logic              r_ss_lock, r_ovf;
   logic              r_lm_wstart, r_lm_rstart, r_sm_start, r_ls_rdone;
   logic [31:0]       r_lm_waddr, r_lm_raddr;
   logic [DATA_W-1:0] r_lm_wdata, r_sm_data, r_ls_rdata;
   logic [STRB_W-1:0] r_lm_wstrb, r_sm_tstrb, r_sm_tkeep;
   logic [USER_W-1:0] r_sm_user;
   logic              r_sm_tlast;
   logic              w_ls_cand, w_ss_cand, w_gnt_ls, w_gnt_ss;
   logic [31:0]       w_lm_addr;

   // While a packet is in flight (ss_lock) LS may not cut in.
   assign w_ls_cand = w_ls_vld && !r_ss_lock;
   assign w_ss_cand = w_ss_vld && !bus.bk_sm_nordy;
   assign w_gnt_ls  = (r_state == IDLE) && w_ls_cand &&
                      (!w_ss_cand || r_last == GNT_SS);
   assign w_gnt_ss  = (r_state == IDLE) && w_ss_cand && !w_gnt_ls;
   assign w_lm_addr = LM_BASE | 32'(w_ls_addr);

   // A done coinciding with its own start pulse belongs to nothing.
   assign w_ls_pop = ((r_state == LM_WR) && bus.bk_lm_wdone && !r_lm_wstart) ||
                     ((r_state == LM_RD) && bus.bk_lm_rdone && !r_lm_rstart);
   assign w_ss_pop = (r_state == SM_TX) && bus.bk_sm_done && !r_sm_start;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_state     <= IDLE;
         r_last      <= GNT_SS;
         r_ss_lock   <= 1'b0;
         r_lm_wstart <= 1'b0;
         r_lm_rstart <= 1'b0;
         r_sm_start  <= 1'b0;
         r_ls_rdone  <= 1'b0;
         r_lm_waddr  <= '0;
         r_lm_raddr  <= '0;
         r_lm_wdata  <= '0;
         r_lm_wstrb  <= '0;
         r_ls_rdata  <= '0;
         r_sm_data   <= '0;
         r_sm_tstrb  <= '0;
         r_sm_tkeep  <= '0;
         r_sm_user   <= '0;
         r_sm_tlast  <= 1'b0;
      end else begin
         r_lm_wstart <= 1'b0;
         r_lm_rstart <= 1'b0;
         r_sm_start  <= 1'b0;
         r_ls_rdone  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt_ls) begin
                  r_last <= GNT_LS;
                  if (w_ls_is_rd) begin
                     r_state     <= LM_RD;
                     r_lm_rstart <= 1'b1;
                     r_lm_raddr  <= w_lm_addr;
                  end else begin
                     r_state     <= LM_WR;
                     r_lm_wstart <= 1'b1;
                     r_lm_waddr  <= w_lm_addr;
                     r_lm_wdata  <= w_ls_data;
                     r_lm_wstrb  <= w_ls_strb;
                  end
               end else if (w_gnt_ss) begin
                  r_last     <= GNT_SS;
                  r_state    <= SM_TX;
                  r_sm_start <= 1'b1;
                  r_sm_data  <= w_ss_data;
                  r_sm_tstrb <= w_ss_tstrb;
                  r_sm_tkeep <= w_ss_tkeep;
                  r_sm_user  <= w_ss_user;
                  r_sm_tlast <= w_ss_tlast;
               end
            end
            LM_WR: if (w_ls_pop) r_state <= IDLE;
            LM_RD: if (w_ls_pop) begin
               r_ls_rdata <= bus.bk_lm_rdata;
               r_ls_rdone <= 1'b1;
               r_state    <= IDLE;
            end
            SM_TX: if (w_ss_pop) begin
               if (SS_PKT_MODE) r_ss_lock <= !r_sm_tlast;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as irq_clr keeps it set.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         r_ovf   <= 1'b0;
         r_ss_en <= 1'b0;
      end else begin
         r_ss_en <= 1'b1;
         if (w_ls_drop)    r_ovf <= 1'b1;
         else if (irq_clr) r_ovf <= 1'b0;
      end
   end

   assign axi_interrupt    = r_ovf;
   assign bus.bk_ls_rdata  = r_ls_rdata;
   assign bus.bk_ls_rdone  = r_ls_rdone;
   assign bus.bk_lm_wstart = r_lm_wstart;
   assign bus.bk_lm_rstart = r_lm_rstart;
   assign bus.bk_lm_waddr  = r_lm_waddr;
   assign bus.bk_lm_raddr  = r_lm_raddr;
   assign bus.bk_lm_wdata  = r_lm_wdata;
   assign bus.bk_lm_wstrb  = r_lm_wstrb;
   assign bus.bk_sm_start  = r_sm_start;
   assign bus.bk_sm_data   = r_sm_data;
   assign bus.bk_sm_tstrb  = r_sm_tstrb;
   assign bus.bk_sm_tkeep  = r_sm_tkeep;
   assign bus.bk_sm_user   = r_sm_user;
   assign bus.bk_sm_tlast  = r_sm_tlast;
endmodule

// File: tb/tb_axi_ctrl_arb.sv
module tb_axi_ctrl_arb;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       irq;
   logic       irq_clr = 1'b0;
   logic [3:0] ls_level, ss_level;
   int         vectors = 0;
   int         miscompares = 0;

   // Start log filled by run_grants: kind 0 = LM write, 1 = LM read, 2 = SM
   int          g_n;
   int          g_kind [8];
   logic [31:0] g_val  [8];
   int          g_cyc  [8];

   axi_ctrl_arb_if #(.ADDR_W(15), .DATA_W(32), .USER_W(2)) bus ();

   axi_ctrl_arb #(
      .ADDR_W(15), .DATA_W(32), .USER_W(2), .LS_DEPTH(8), .SS_DEPTH(8),
      .SS_PKT_MODE(1'b1), .LM_BASE(32'h3000_0000)
   ) dut (
      .axi_aclk(clk), .axi_areset(rst), .axi_interrupt(irq), .irq_clr(irq_clr),
      .ls_level(ls_level), .ss_level(ss_level), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      bus.bk_ls_wstart = 0; bus.bk_ls_rstart = 0;
      bus.bk_ls_waddr = '0; bus.bk_ls_raddr = '0;
      bus.bk_ls_wdata = '0; bus.bk_ls_wstrb = '0;
      bus.bk_lm_wdone = 0; bus.bk_lm_rdone = 0; bus.bk_lm_rdata = '0;
      bus.bk_ss_data = '0; bus.bk_ss_tstrb = '0; bus.bk_ss_tkeep = '0;
      bus.bk_ss_user = '0; bus.bk_ss_tlast = 0; bus.bk_ss_valid = 0;
      bus.bk_sm_nordy = 0; bus.bk_sm_done = 0;
      irq_clr = 0;
   endtask

   task automatic do_reset();
      zero_inputs();
      rst = 1; tick(); tick();
      rst = 0; tick();
   endtask

   task automatic ls_wr(input logic [14:0] a, input logic [31:0] d);
      bus.bk_ls_wstart = 1; bus.bk_ls_waddr = a;
      bus.bk_ls_wdata = d; bus.bk_ls_wstrb = 4'hF;
   endtask

   task automatic ss_beat(input logic [31:0] d, input logic last);
      bus.bk_ss_valid = 1; bus.bk_ss_data = d; bus.bk_ss_tlast = last;
      bus.bk_ss_tstrb = 4'hF; bus.bk_ss_tkeep = 4'hF;
   endtask

   // Backend responder: answers each start with done one cycle later and
   // logs starts (cycle relative to call) until n starts or budget runs out.
   task automatic run_grants(input int n, input int budget);
      logic pw, pr, ps;
      pw = 0; pr = 0; ps = 0; g_n = 0;
      for (int c = 0; c < budget && g_n < n; c++) begin
         bus.bk_lm_wdone = pw; bus.bk_lm_rdone = pr; bus.bk_sm_done = ps;
         pw = bus.bk_lm_wstart; pr = bus.bk_lm_rstart; ps = bus.bk_sm_start;
         if (g_n < 8 && (pw || pr || ps)) begin
            g_kind[g_n] = pw ? 0 : (pr ? 1 : 2);
            g_val[g_n]  = pw ? bus.bk_lm_waddr : (pr ? bus.bk_lm_raddr : bus.bk_sm_data);
            g_cyc[g_n]  = c;
            g_n++;
         end
         tick();
      end
      bus.bk_lm_wdone = pw; bus.bk_lm_rdone = pr; bus.bk_sm_done = ps;
      tick();
      bus.bk_lm_wdone = 0; bus.bk_lm_rdone = 0; bus.bk_sm_done = 0;
   endtask

   task automatic test_reset();
      zero_inputs();
      rst = 1; tick();
      vectors++;
      if ({bus.bk_lm_wstart, bus.bk_lm_rstart, bus.bk_sm_start, bus.bk_ls_rdone} !== 4'b0) begin
         miscompares++; $display("FAIL rst_starts: got %b want 0000",
            {bus.bk_lm_wstart, bus.bk_lm_rstart, bus.bk_sm_start, bus.bk_ls_rdone});
      end
      vectors++;
      if ({bus.bk_ss_ready, irq} !== 2'b0) begin
         miscompares++; $display("FAIL rst_ready_irq: got %b want 00", {bus.bk_ss_ready, irq});
      end
      vectors++;
      if ({ls_level, ss_level} !== 8'h0) begin
         miscompares++; $display("FAIL rst_levels: got %h want 00", {ls_level, ss_level});
      end
      vectors++;
      if ({bus.bk_lm_waddr, bus.bk_ls_rdata, bus.bk_sm_data} !== 96'h0) begin
         miscompares++; $display("FAIL rst_payload: got %h want 0",
            {bus.bk_lm_waddr, bus.bk_ls_rdata, bus.bk_sm_data});
      end
      rst = 0; tick();
      vectors++;
      if (bus.bk_ss_ready !== 1'b1) begin
         miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.bk_ss_ready);
      end
   endtask

   task automatic test_ls_write();
      do_reset();
      ls_wr(15'h0010, 32'hA5A5_0001);
      tick(); bus.bk_ls_wstart = 0;
      vectors++;
      if (bus.bk_lm_wstart !== 1'b0 || ls_level !== 4'd1) begin
         miscompares++; $display("FAIL wr_c1: got start=%b lvl=%0d want 0/1", bus.bk_lm_wstart, ls_level);
      end
      tick();
      vectors++;
      if (bus.bk_lm_wstart !== 1'b1) begin
         miscompares++; $display("FAIL wr_start_c2: got %b want 1", bus.bk_lm_wstart);
      end
      vectors++;
      if (bus.bk_lm_waddr !== 32'h3000_0010 || bus.bk_lm_wdata !== 32'hA5A5_0001 || bus.bk_lm_wstrb !== 4'hF) begin
         miscompares++; $display("FAIL wr_payload: got %h/%h/%h want 30000010/a5a50001/f",
            bus.bk_lm_waddr, bus.bk_lm_wdata, bus.bk_lm_wstrb);
      end
      tick();
      vectors++;
      if (bus.bk_lm_wstart !== 1'b0 || bus.bk_lm_waddr !== 32'h3000_0010) begin
         miscompares++; $display("FAIL wr_pulse_hold: got start=%b addr=%h want 0/30000010",
            bus.bk_lm_wstart, bus.bk_lm_waddr);
      end
      bus.bk_lm_wdone = 1; tick(); bus.bk_lm_wdone = 0;
      vectors++;
      if (ls_level !== 4'd0) begin
         miscompares++; $display("FAIL wr_pop: got lvl=%0d want 0", ls_level);
      end
   endtask

   task automatic test_ls_read();
      do_reset();
      bus.bk_ls_rstart = 1; bus.bk_ls_raddr = 15'h0004;
      tick(); bus.bk_ls_rstart = 0;
      tick();
      vectors++;
      if (bus.bk_lm_rstart !== 1'b1 || bus.bk_lm_raddr !== 32'h3000_0004) begin
         miscompares++; $display("FAIL rd_start: got %b/%h want 1/30000004", bus.bk_lm_rstart, bus.bk_lm_raddr);
      end
      // done coinciding with start must be ignored
      bus.bk_lm_rdone = 1; bus.bk_lm_rdata = 32'h1111_1111;
      tick(); bus.bk_lm_rdone = 0;
      vectors++;
      if (bus.bk_ls_rdone !== 1'b0 || ls_level !== 4'd1) begin
         miscompares++; $display("FAIL rd_early_done: got rdone=%b lvl=%0d want 0/1", bus.bk_ls_rdone, ls_level);
      end
      bus.bk_lm_rdone = 1; bus.bk_lm_rdata = 32'hDEAD_BEEF;
      tick(); bus.bk_lm_rdone = 0; bus.bk_lm_rdata = 32'h0;
      vectors++;
      if (bus.bk_ls_rdone !== 1'b1 || bus.bk_ls_rdata !== 32'hDEAD_BEEF || ls_level !== 4'd0) begin
         miscompares++; $display("FAIL rd_return: got %b/%h/%0d want 1/deadbeef/0",
            bus.bk_ls_rdone, bus.bk_ls_rdata, ls_level);
      end
      tick();
      vectors++;
      if (bus.bk_ls_rdone !== 1'b0 || bus.bk_ls_rdata !== 32'hDEAD_BEEF) begin
         miscompares++; $display("FAIL rd_hold: got %b/%h want 0/deadbeef", bus.bk_ls_rdone, bus.bk_ls_rdata);
      end
   endtask

   task automatic test_alternate();
      int          ek [4];
      logic [31:0] ev [4];
      ek = '{0, 2, 0, 2};
      ev = '{32'h3000_0001, 32'h0000_5501, 32'h3000_0002, 32'h0000_5502};
      do_reset();
      ls_wr(15'h0001, 32'h1); ss_beat(32'h5501, 1'b1);
      tick();
      ls_wr(15'h0002, 32'h2); ss_beat(32'h5502, 1'b1);
      tick();
      bus.bk_ls_wstart = 0; bus.bk_ss_valid = 0;
      // now at cycle 2 after the first push
      run_grants(4, 40);
      vectors++;
      if (g_n !== 4) begin
         miscompares++; $display("FAIL alt_count: got %0d starts want 4", g_n);
      end
      for (int i = 0; i < g_n && i < 4; i++) begin
         vectors++;
         if (g_kind[i] !== ek[i] || g_val[i] !== ev[i] || g_cyc[i] !== 3*i) begin
            miscompares++; $display("FAIL alt_grant%0d: got kind=%0d val=%h cyc=%0d want %0d/%h/%0d",
               i, g_kind[i], g_val[i], g_cyc[i], ek[i], ev[i], 3*i);
         end
      end
   endtask

   task automatic test_pkt_mode();
      int          ek [3];
      logic [31:0] ev [3];
      ek = '{2, 2, 0};
      ev = '{32'h0000_B002, 32'h0000_C003, 32'h3000_0020};
      do_reset();
      ss_beat(32'hA001, 1'b0);
      tick();
      ss_beat(32'hB002, 1'b0); ls_wr(15'h0020, 32'h77);
      tick();
      ss_beat(32'hC003, 1'b1); bus.bk_ls_wstart = 0;
      vectors++;
      if (bus.bk_sm_start !== 1'b1 || bus.bk_sm_data !== 32'hA001) begin
         miscompares++; $display("FAIL pkt_first: got %b/%h want 1/a001", bus.bk_sm_start, bus.bk_sm_data);
      end
      tick();
      bus.bk_ss_valid = 0; bus.bk_sm_done = 1; bus.bk_sm_nordy = 1;
      tick();
      bus.bk_sm_done = 0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.bk_sm_start !== 1'b0 || bus.bk_lm_wstart !== 1'b0) begin
            miscompares++; $display("FAIL pkt_stall%0d: got sm=%b lm=%b want 0/0",
               i, bus.bk_sm_start, bus.bk_lm_wstart);
         end
         tick();
      end
      bus.bk_sm_nordy = 0;
      run_grants(3, 40);
      vectors++;
      if (g_n !== 3) begin
         miscompares++; $display("FAIL pkt_count: got %0d starts want 3", g_n);
      end
      for (int i = 0; i < g_n && i < 3; i++) begin
         vectors++;
         if (g_kind[i] !== ek[i] || g_val[i] !== ev[i] || g_cyc[i] !== 1 + 3*i) begin
            miscompares++; $display("FAIL pkt_grant%0d: got kind=%0d val=%h cyc=%0d want %0d/%h/%0d",
               i, g_kind[i], g_val[i], g_cyc[i], ek[i], ev[i], 1 + 3*i);
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         ls_wr(15'(i), 32'(i));
         tick();
      end
      bus.bk_ls_wstart = 0;
      vectors++;
      if (ls_level !== 4'd8 || irq !== 1'b1) begin
         miscompares++; $display("FAIL ovf_full: got lvl=%0d irq=%b want 8/1", ls_level, irq);
      end
      tick();
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++; $display("FAIL ovf_sticky: got %b want 1", irq);
      end
      irq_clr = 1; tick(); irq_clr = 0;
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++; $display("FAIL ovf_clear: got %b want 0", irq);
      end
      // drop and clear together: flag stays set
      ls_wr(15'h7F, 32'h0); irq_clr = 1;
      tick(); bus.bk_ls_wstart = 0; irq_clr = 0;
      vectors++;
      if (irq !== 1'b1 || ls_level !== 4'd8) begin
         miscompares++; $display("FAIL ovf_set_clr: got irq=%b lvl=%0d want 1/8", irq, ls_level);
      end
   endtask

   task automatic test_dual_req();
      do_reset();
      ls_wr(15'h0033, 32'h3333); bus.bk_ls_rstart = 1; bus.bk_ls_raddr = 15'h0044;
      tick(); bus.bk_ls_wstart = 0; bus.bk_ls_rstart = 0;
      vectors++;
      if (ls_level !== 4'd1 || irq !== 1'b1) begin
         miscompares++; $display("FAIL dual_queue: got lvl=%0d irq=%b want 1/1", ls_level, irq);
      end
      tick();
      vectors++;
      if (bus.bk_lm_wstart !== 1'b1 || bus.bk_lm_rstart !== 1'b0 || bus.bk_lm_waddr !== 32'h3000_0033) begin
         miscompares++; $display("FAIL dual_write: got w=%b r=%b addr=%h want 1/0/30000033",
            bus.bk_lm_wstart, bus.bk_lm_rstart, bus.bk_lm_waddr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ss_beat(32'hD00D, 1'b1);
      tick(); bus.bk_ss_valid = 0;
      tick();
      vectors++;
      if (bus.bk_sm_start !== 1'b1 || bus.bk_sm_data !== 32'hD00D) begin
         miscompares++; $display("FAIL mid_start: got %b/%h want 1/d00d", bus.bk_sm_start, bus.bk_sm_data);
      end
      tick();
      rst = 1; #1;
      vectors++;
      if ({bus.bk_sm_start, bus.bk_ss_ready, irq, bus.bk_sm_tlast} !== 4'b0 || bus.bk_sm_data !== 32'h0
          || {ls_level, ss_level} !== 8'h0) begin
         miscompares++; $display("FAIL mid_reset: got st=%b rdy=%b data=%h lvl=%h want 0/0/0/00",
            bus.bk_sm_start, bus.bk_ss_ready, bus.bk_sm_data, {ls_level, ss_level});
      end
      tick(); rst = 0; tick();
      vectors++;
      if (bus.bk_ss_ready !== 1'b1) begin
         miscompares++; $display("FAIL mid_ready: got %b want 1", bus.bk_ss_ready);
      end
      ss_beat(32'hE00E, 1'b1);
      tick(); bus.bk_ss_valid = 0;
      tick();
      vectors++;
      if (bus.bk_sm_start !== 1'b1 || bus.bk_sm_data !== 32'hE00E) begin
         miscompares++; $display("FAIL mid_fresh: got %b/%h want 1/e00e", bus.bk_sm_start, bus.bk_sm_data);
      end
      tick();
      bus.bk_sm_done = 1; tick(); bus.bk_sm_done = 0;
      vectors++;
      if (ss_level !== 4'd0) begin
         miscompares++; $display("FAIL mid_pop: got %0d want 0", ss_level);
      end
   endtask

   initial begin
      test_reset();
      test_ls_write();
      test_ls_read();
      test_alternate();
      test_pkt_mode();
      test_overflow();
      test_dual_req();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
